// File: rtl/csr_rmw_unit_pkg.sv
// Shared types and the read-modify-write rule for the CSR RMW unit.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_WRITE_NONE = 2'd0,
    CSR_WRITE_RW   = 2'd1,
    CSR_WRITE_RS   = 2'd2,
    CSR_WRITE_RC   = 2'd3
  } csr_write_func;

  typedef enum logic {
    CSR_INPUT_REG = 1'b0,
    CSR_INPUT_IMM = 1'b1
  } csr_input_sel;

  typedef enum logic [2:0] {
    CSR_F3_RW  = 3'b001,
    CSR_F3_RS  = 3'b010,
    CSR_F3_RC  = 3'b011,
    CSR_F3_RWI = 3'b101,
    CSR_F3_RSI = 3'b110,
    CSR_F3_RCI = 3'b111
  } csr_funct3_t;

  typedef enum logic [1:0] {
    CSR_S_IDLE    = 2'd0,
    CSR_S_ACCESS  = 2'd1,
    CSR_S_RESPOND = 2'd2
  } csr_fsm_state_t;

  localparam logic [1:0] CSR_RO_BITS = 2'b11;

  // Widest supported XLEN; callers widen into and truncate out of this word.
  localparam int unsigned CSR_MAX_XLEN = 64;
  typedef logic [CSR_MAX_XLEN-1:0] csr_word_t;

  function automatic csr_word_t csr_rmw(input csr_word_t old, input csr_word_t operand,
                                        input csr_write_func func);
    unique case (func)
      CSR_WRITE_RW: return operand;
      CSR_WRITE_RS: return old | operand;
      CSR_WRITE_RC: return old & ~operand;
      default:      return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_rmw_unit_if.sv
// Request/response handshake bundle between the CSR decode stage and the RMW unit.
interface csr_rmw_if #(
  parameter int unsigned XLEN = 32
);
  import csr_pkg::*;

  logic              in_valid;
  logic              in_ready;
  csr_write_func     in_write_func;
  csr_input_sel      in_input_sel;
  logic [11:0]       in_addr;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1_or_uimm;
  logic [XLEN-1:0]   in_rs1_value;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rdata;
  logic [4:0]        out_rd;
  logic              out_rd_write;
  logic              out_illegal;

  modport master (
    output in_valid, in_write_func, in_input_sel, in_addr, in_rd, in_rs1_or_uimm,
           in_rs1_value, out_ready,
    input  in_ready, out_valid, out_rdata, out_rd, out_rd_write, out_illegal
  );

  modport slave (
    input  in_valid, in_write_func, in_input_sel, in_addr, in_rd, in_rs1_or_uimm,
           in_rs1_value, out_ready,
    output in_ready, out_valid, out_rdata, out_rd, out_rd_write, out_illegal
  );

endinterface

// File: rtl/csr_rmw_unit_bank.sv
// CSR register array with one write port, one read port and a free-running cycle counter.
module csr_bank #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_CSRS  = 8,
  parameter int unsigned CYCLE_IDX = 0,
  localparam int unsigned IDX_W    = $clog2(NUM_CSRS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [XLEN-1:0]  rdata_o
);

  logic [XLEN-1:0] regs_q [NUM_CSRS];

  // NOTE: this array is a handful of flops that must read as zero after reset,
  // so it is reset explicitly; a RAM-style array would be left unreset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CSRS); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CSRS); i++) begin
        // A committing write to the counter takes precedence over its increment.
        if (we_i && (waddr_i == IDX_W'(i))) regs_q[i] <= wdata_i;
        else if (i == int'(CYCLE_IDX))      regs_q[i] <= regs_q[i] + XLEN'(1);
      end
    end
  end

  assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/csr_rmw_unit.sv
// Zicsr read-modify-write unit: latch a request, access the bank, hold the response.
module csr_rmw_unit import csr_pkg::*; #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_CSRS  = 8,
  parameter logic [11:0] BASE_ADDR = 12'h300,
  parameter int unsigned CYCLE_IDX = 0
) (
  input logic       clk,
  input logic       rst_n,
  csr_rmw_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_CSRS);

  csr_fsm_state_t  state_q;
  csr_write_func   func_q;
  csr_input_sel    sel_q;
  logic [11:0]     addr_q;
  logic [4:0]      rd_q;
  logic [4:0]      rs1_q;
  logic [XLEN-1:0] rs1_val_q;

  logic            out_valid_q;
  logic [XLEN-1:0] out_rdata_q;
  logic [4:0]      out_rd_q;
  logic            out_rd_write_q;
  logic            out_illegal_q;

  logic            read_en;
  logic            write_en;
  logic            in_range;
  logic            illegal;
  logic            commit;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;

  assign read_en  = (func_q != CSR_WRITE_RW) || (rd_q != '0);
  assign write_en = (func_q == CSR_WRITE_RW) || (rs1_q != '0);
  assign in_range = (addr_q[11:IDX_W] == BASE_ADDR[11:IDX_W]);
  assign illegal  = (func_q == CSR_WRITE_NONE) || !in_range
                  || (write_en && (addr_q[11:10] == CSR_RO_BITS));
  assign commit   = (state_q == CSR_S_ACCESS) && !illegal && write_en;
  assign operand  = (sel_q == CSR_INPUT_IMM) ? XLEN'(rs1_q) : rs1_val_q;
  assign new_val  = XLEN'(csr_rmw(CSR_MAX_XLEN'(old_val), CSR_MAX_XLEN'(operand), func_q));

  csr_bank #(
    .XLEN      (XLEN),
    .NUM_CSRS  (NUM_CSRS),
    .CYCLE_IDX (CYCLE_IDX)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (commit),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (new_val),
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (old_val)
  );

  // NOTE: every register here is state, so all updates are non-blocking;
  // a blocking assignment would make later reads in this block see the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= CSR_S_IDLE;
      func_q         <= CSR_WRITE_NONE;
      sel_q          <= CSR_INPUT_REG;
      addr_q         <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs1_val_q      <= '0;
      out_valid_q    <= 1'b0;
      out_rdata_q    <= '0;
      out_rd_q       <= '0;
      out_rd_write_q <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else begin
      unique case (state_q)
        CSR_S_IDLE: begin
          if (bus.in_valid) begin
            func_q    <= bus.in_write_func;
            sel_q     <= bus.in_input_sel;
            addr_q    <= bus.in_addr;
            rd_q      <= bus.in_rd;
            rs1_q     <= bus.in_rs1_or_uimm;
            rs1_val_q <= bus.in_rs1_value;
            state_q   <= CSR_S_ACCESS;
          end
        end
        CSR_S_ACCESS: begin
          out_valid_q    <= 1'b1;
          out_rd_q       <= rd_q;
          out_illegal_q  <= illegal;
          out_rd_write_q <= !illegal && read_en && (rd_q != '0);
          out_rdata_q    <= (!illegal && read_en) ? old_val : '0;
          state_q        <= CSR_S_RESPOND;
        end
        CSR_S_RESPOND: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= CSR_S_IDLE;
          end
        end
        default: state_q <= CSR_S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = rst_n && (state_q == CSR_S_IDLE);
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rdata    = out_rdata_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_rd_write = out_rd_write_q;
  assign bus.out_illegal  = out_illegal_q;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Scoreboard bench for csr_rmw_unit: driver predicts responses, monitors compare them.
module tb_csr_rmw_unit;
  import csr_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned N       = 8;
  localparam logic [11:0] BASE    = 12'h300;
  localparam logic [11:0] RO_BASE = 12'hC00;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_rmw_if #(.XLEN(XLEN)) bus ();
  csr_rmw_if #(.XLEN(XLEN)) bus_ro ();

  csr_rmw_unit #(.XLEN(XLEN), .NUM_CSRS(N), .BASE_ADDR(BASE), .CYCLE_IDX(0)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus)
  );

  // Second instance mapped onto the read-only window (counter parked at entry 7).
  csr_rmw_unit #(.XLEN(XLEN), .NUM_CSRS(N), .BASE_ADDR(RO_BASE), .CYCLE_IDX(7)) u_dut_ro (
    .clk (clk), .rst_n (rst_n), .bus (bus_ro)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rd_write;
    logic        illegal;
    string       name;
  } resp_t;

  resp_t exp_q[$];
  resp_t exp_ro_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model: plain CSR values plus the counter as "value at a known edge".
  logic [31:0] mem [N];
  logic [31:0] cyc_base = '0;
  int unsigned cyc_edge = 0;
  int unsigned edge_cnt = 0;
  int          stall_left = 0;
  bit          always_rdy = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] cnt_at(input int unsigned e);
    return cyc_base + 32'(e - cyc_edge);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_resp(input resp_t e, input logic [31:0] rdata, input logic [4:0] rd,
                          input logic rdw, input logic ill);
    check({e.name, ".rdata"},    64'(rdata), 64'(e.rdata));
    check({e.name, ".rd"},       64'(rd),    64'(e.rd));
    check({e.name, ".rd_write"}, 64'(rdw),   64'(e.rd_write));
    check({e.name, ".illegal"},  64'(ill),   64'(e.illegal));
  endtask

  task automatic issue(input bit ro, input string name, input csr_write_func f,
                       input csr_input_sel s, input logic [11:0] a, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [31:0] v);
    logic [11:0] base = ro ? RO_BASE : BASE;
    int          idx  = int'(a) - int'(base);
    bit          in_rng, rden, wren, legal;
    logic [31:0] old, opnd, nv;
    int unsigned n_edge;
    int          guard = 0;
    resp_t       e;
    in_rng = (idx >= 0) && (idx < int'(N));
    @(negedge clk);
    while ((ro ? bus_ro.in_ready : bus.in_ready) !== 1'b1) begin
      if (++guard > 200) begin
        n_cmp++; n_err++;
        $display("FAIL %s.accept_timeout: in_ready never rose, want 1", name);
        return;
      end
      @(negedge clk);
    end
    n_edge = edge_cnt + 1;
    if (ro) begin
      bus_ro.in_write_func = f; bus_ro.in_input_sel = s; bus_ro.in_addr = a;
      bus_ro.in_rd = rd; bus_ro.in_rs1_or_uimm = r1; bus_ro.in_rs1_value = v;
      bus_ro.in_valid = 1'b1;
    end else begin
      bus.in_write_func = f; bus.in_input_sel = s; bus.in_addr = a;
      bus.in_rd = rd; bus.in_rs1_or_uimm = r1; bus.in_rs1_value = v;
      bus.in_valid = 1'b1;
    end
    rden  = (f != CSR_WRITE_RW) || (rd != 0);
    wren  = (f == CSR_WRITE_RW) || (r1 != 0);
    legal = (f != CSR_WRITE_NONE) && in_rng && !(wren && a[11:10] == 2'b11);
    // The read-only instance is only ever read at entries that nothing writes.
    if (!in_rng || ro) old = '0;
    else if (idx == 0) old = cnt_at(n_edge);
    else               old = mem[idx];
    opnd = (s == CSR_INPUT_IMM) ? {27'd0, r1} : v;
    case (f)
      CSR_WRITE_RW: nv = opnd;
      CSR_WRITE_RS: nv = old | opnd;
      CSR_WRITE_RC: nv = old & ~opnd;
      default:      nv = old;
    endcase
    if (legal && wren && !ro) begin
      if (idx == 0) begin cyc_base = nv; cyc_edge = n_edge + 1; end
      else mem[idx] = nv;
    end
    e.rdata = (legal && rden) ? old : '0;
    e.rd = rd;
    e.rd_write = legal && rden && (rd != 0);
    e.illegal = !legal;
    e.name = name;
    if (ro) exp_ro_q.push_back(e); else exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (ro) bus_ro.in_valid = 1'b0; else bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid",    64'(bus.out_valid),    0);
    check("rst.in_ready",     64'(bus.in_ready),     0);
    check("rst.out_rdata",    64'(bus.out_rdata),    0);
    check("rst.out_rd",       64'(bus.out_rd),       0);
    check("rst.out_rd_write", 64'(bus.out_rd_write), 0);
    check("rst.out_illegal",  64'(bus.out_illegal),  0);
    exp_q.delete();
    exp_ro_q.delete();
    for (int i = 0; i < int'(N); i++) mem[i] = '0;
    cyc_base = '0;
    cyc_edge = edge_cnt;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 || exp_ro_q.size() != 0) begin
      @(negedge clk);
      if (++g > 500) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size() + exp_ro_q.size());
        exp_q.delete(); exp_ro_q.delete();
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Main monitor: owns out_ready, checks held responses every stalled cycle.
  initial begin : monitor
    resp_t e;
    bit    rdy;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        bus.out_ready = 1'b0;
      end else if (bus.out_valid === 1'b1) begin
        if (stall_left > 0) begin stall_left--; rdy = 1'b0; end
        else rdy = always_rdy || ($urandom_range(0, 3) != 0);
        bus.out_ready = rdy;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_resp: out_valid=1 with no request outstanding, want 0");
          bus.out_ready = 1'b1;
        end else if (rdy) begin
          e = exp_q.pop_front();
          cmp_resp(e, bus.out_rdata, bus.out_rd, bus.out_rd_write, bus.out_illegal);
        end else begin
          e = exp_q[0];
          e.name = {e.name, ".held"};
          cmp_resp(e, bus.out_rdata, bus.out_rd, bus.out_rd_write, bus.out_illegal);
          check({e.name, ".in_ready"}, 64'(bus.in_ready), 0);
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : monitor_ro
    resp_t e;
    bus_ro.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus_ro.out_valid === 1'b1) begin
        if (exp_ro_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL ro.spurious_resp: out_valid=1 with no request outstanding, want 0");
        end else begin
          e = exp_ro_q.pop_front();
          cmp_resp(e, bus_ro.out_rdata, bus_ro.out_rd, bus_ro.out_rd_write, bus_ro.out_illegal);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.in_valid = 1'b0; bus.in_write_func = CSR_WRITE_NONE; bus.in_input_sel = CSR_INPUT_REG;
    bus.in_addr = '0; bus.in_rd = '0; bus.in_rs1_or_uimm = '0; bus.in_rs1_value = '0;
    bus_ro.in_valid = 1'b0; bus_ro.in_write_func = CSR_WRITE_NONE; bus_ro.in_input_sel = CSR_INPUT_REG;
    bus_ro.in_addr = '0; bus_ro.in_rd = '0; bus_ro.in_rs1_or_uimm = '0; bus_ro.in_rs1_value = '0;
    do_reset(3);

    // Basic write then read-back without write.
    issue(0, "rw301",    CSR_WRITE_RW, CSR_INPUT_REG, 12'h301, 5'd5, 5'd1, 32'hDEAD_BEEF);
    issue(0, "rd301",    CSR_WRITE_RS, CSR_INPUT_REG, 12'h301, 5'd6, 5'd0, 32'hFFFF_FFFF);
    // Set and clear bits on a preloaded entry.
    issue(0, "load301",  CSR_WRITE_RW, CSR_INPUT_REG, 12'h301, 5'd0, 5'd2, 32'h0000_F0F0);
    issue(0, "rsi301",   CSR_WRITE_RS, CSR_INPUT_IMM, 12'h301, 5'd7, 5'h0F, 32'h0);
    issue(0, "rd301_b",  CSR_WRITE_RS, CSR_INPUT_REG, 12'h301, 5'd8, 5'd0, 32'h0);
    issue(0, "rci301",   CSR_WRITE_RC, CSR_INPUT_IMM, 12'h301, 5'd9, 5'h0F, 32'h0);
    issue(0, "rd301_c",  CSR_WRITE_RS, CSR_INPUT_REG, 12'h301, 5'd8, 5'd0, 32'h0);
    // Read/write suppression.
    issue(0, "rw302_x0", CSR_WRITE_RW, CSR_INPUT_REG, 12'h302, 5'd0, 5'd3, 32'h0000_1234);
    issue(0, "rc302_x0", CSR_WRITE_RC, CSR_INPUT_REG, 12'h302, 5'd4, 5'd0, 32'hFFFF_FFFF);
    issue(0, "rd302",    CSR_WRITE_RS, CSR_INPUT_REG, 12'h302, 5'd4, 5'd0, 32'h0);
    // Illegal accesses.
    issue(0, "ill310",   CSR_WRITE_RS, CSR_INPUT_REG, 12'h310, 5'd1, 5'd0, 32'h0);
    issue(0, "illC00rw", CSR_WRITE_RW, CSR_INPUT_REG, 12'hC00, 5'd1, 5'd2, 32'h5);
    issue(0, "illC00rs", CSR_WRITE_RS, CSR_INPUT_IMM, 12'hC00, 5'd1, 5'd0, 32'h0);
    issue(0, "illnone",  CSR_WRITE_NONE, CSR_INPUT_REG, 12'h301, 5'd1, 5'd0, 32'h0);
    drain();

    // Counter: back-to-back reads, then write all-ones and observe the wrap.
    always_rdy = 1'b1;
    for (int i = 0; i < 3; i++) issue(0, "cyc_rd", CSR_WRITE_RS, CSR_INPUT_REG, 12'h300, 5'd10, 5'd0, 32'h0);
    issue(0, "cyc_wr",   CSR_WRITE_RW, CSR_INPUT_REG, 12'h300, 5'd11, 5'd1, 32'hFFFF_FFFF);
    issue(0, "cyc_wrap", CSR_WRITE_RS, CSR_INPUT_REG, 12'h300, 5'd12, 5'd0, 32'h0);
    drain();

    // Long back-pressure on one response.
    stall_left = 10;
    issue(0, "stall301", CSR_WRITE_RS, CSR_INPUT_REG, 12'h301, 5'd13, 5'd0, 32'h0);
    drain();
    always_rdy = 1'b0;

    // Reset while the request is in ACCESS: nothing survives.
    issue(0, "dropped",  CSR_WRITE_RW, CSR_INPUT_REG, 12'h302, 5'd3, 5'd1, 32'h0000_AAAA);
    do_reset(1);
    issue(0, "post_rst302", CSR_WRITE_RS, CSR_INPUT_REG, 12'h302, 5'd3, 5'd0, 32'h0);
    issue(0, "post_rst301", CSR_WRITE_RS, CSR_INPUT_REG, 12'h301, 5'd3, 5'd0, 32'h0);
    drain();

    // Read-only window on the second instance.
    issue(1, "ro_rsi0",  CSR_WRITE_RS, CSR_INPUT_IMM, 12'hC00, 5'd2, 5'd0, 32'h0);
    issue(1, "ro_rw",    CSR_WRITE_RW, CSR_INPUT_REG, 12'hC01, 5'd2, 5'd0, 32'h1);
    issue(1, "ro_rs_x0", CSR_WRITE_RS, CSR_INPUT_REG, 12'hC02, 5'd4, 5'd0, 32'hFFFF);
    issue(1, "ro_rci",   CSR_WRITE_RC, CSR_INPUT_IMM, 12'hC03, 5'd4, 5'd5, 32'h0);
    issue(1, "ro_range", CSR_WRITE_RS, CSR_INPUT_IMM, 12'hD00, 5'd4, 5'd0, 32'h0);
    drain();

    // Randomized traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      int unsigned sel = $urandom_range(0, 9);
      logic [11:0] a;
      logic [4:0]  rd, r1;
      if (sel < 8)       a = BASE + 12'(sel);
      else if (sel == 8) a = 12'h308 + 12'($urandom_range(0, 7));
      else               a = {2'b11, 10'($urandom)};
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      issue(0, "rand", csr_write_func'($urandom_range(0, 3)), csr_input_sel'($urandom_range(0, 1)),
            a, rd, r1, $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
